// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: sequences each instruction through shared ALU/memory,
// with memory wait-state timeout, sticky fault trap and retired-instruction counter.
module mc_controller #(
  parameter int WAIT_LIMIT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opCode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUcontrol,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       pcSel,
  output logic             pcWrite,
  output logic             irWrite,
  output logic             iord,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic [1:0]       regWriteDataSel,
  output logic [1:0]       regIn,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b100000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR, S_MEM_RD,
    S_WB_M, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_FAULT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WCW-1:0]   r_wait;
  logic [1:0]       r_fault;
  logic [CNT_W-1:0] r_retired;
  logic [1:0]       w_fault_code;
  logic             w_wait_state;
  logic             w_timeout;
  logic             w_pc_write;
  logic             w_ir_write;
  logic             w_mem_write;
  logic             w_reg_write;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // Last permitted wait cycle without mem_ready: this edge traps instead of waiting again.
  assign w_timeout    = w_wait_state && !mem_ready && (r_wait == WCW'(WAIT_LIMIT - 1));

  // State, wait counter, sticky fault code and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_fault   <= 2'b00;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_wait_state && !mem_ready) begin
        r_wait <= r_wait + WCW'(1);
      end
      if ((w_next == S_FAULT) && (r_state != S_FAULT)) begin
        r_fault <= w_fault_code;
      end
      if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_next          = r_state;
    w_fault_code    = 2'b00;
    ALUcontrol      = 2'b00;
    aluSrcA         = 1'b0;
    aluSrcB         = 2'b00;
    pcSel           = 2'b00;
    iord            = 1'b0;
    memRead         = 1'b0;
    regWriteDataSel = 2'b00;
    regIn           = 2'b00;
    w_pc_write      = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_write     = 1'b0;
    w_reg_write     = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead    = 1'b1;
        aluSrcB    = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = 2'b10;
        end else if (mem_ready) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opCode)
          OP_RTYPE:        w_next = S_EXEC_R;
          OP_ADDI, OP_ANDI: w_next = S_EXEC_I;
          OP_LW, OP_SW:    w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J:            w_next = S_JUMP;
          OP_JAL:          w_next = S_JAL;
          OP_JR:           w_next = S_JR;
          default: begin
            w_next       = S_FAULT;
            w_fault_code = 2'b01;
          end
        endcase
      end
      S_EXEC_R: begin
        aluSrcA    = 1'b1;
        ALUcontrol = 2'b10;
        w_next     = S_WB_R;
      end
      S_WB_R: begin
        w_reg_write = 1'b1;
        regIn       = 2'b01;
        w_next      = S_FETCH;
      end
      S_EXEC_I: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        ALUcontrol = (opCode == OP_ANDI) ? 2'b11 : 2'b00;
        w_next     = S_WB_I;
      end
      S_WB_I: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = (opCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord    = 1'b1;
        memRead = 1'b1;
        if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = 2'b10;
        end else if (mem_ready) begin
          w_next = S_WB_M;
        end else begin
          w_next = S_MEM_RD;
        end
      end
      S_WB_M: begin
        w_reg_write     = 1'b1;
        regWriteDataSel = 2'b01;
        w_next          = S_FETCH;
      end
      S_MEM_WR: begin
        iord        = 1'b1;
        w_mem_write = 1'b1;
        if (w_timeout) begin
          w_next       = S_FAULT;
          w_fault_code = 2'b10;
        end else if (mem_ready) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_MEM_WR;
        end
      end
      S_BRANCH: begin
        aluSrcA    = 1'b1;
        ALUcontrol = 2'b01;
        pcSel      = 2'b11;
        w_pc_write = (opCode == OP_BEQ) ? zero : ~zero;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pcSel      = 2'b01;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        pcSel           = 2'b01;
        w_pc_write      = 1'b1;
        w_reg_write     = 1'b1;
        regWriteDataSel = 2'b10;
        regIn           = 2'b10;
        w_next          = S_FETCH;
      end
      S_JR: begin
        pcSel      = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        // Unreachable encoding: trap rather than guess an instruction.
        w_next       = S_FAULT;
        w_fault_code = 2'b01;
      end
    endcase
  end

  // Write strobes are suppressed for the whole reset assertion, not just after the edge.
  assign pcWrite  = w_pc_write  & rst_n;
  assign irWrite  = w_ir_write  & rst_n;
  assign memWrite = w_mem_write & rst_n;
  assign regWrite = w_reg_write & rst_n;
  assign fault    = r_fault;
  assign retired  = r_retired;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction cycle sequences are derived from the
// instruction class and wait counts, queued, and compared every cycle by a monitor.
module tb_mc_controller;
  localparam int WAIT_LIMIT = 8;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [5:0]       opCode = 6'b000000;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic [1:0]       ALUcontrol;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       pcSel;
  logic             pcWrite;
  logic             irWrite;
  logic             iord;
  logic             memRead;
  logic             memWrite;
  logic             regWrite;
  logic [1:0]       regWriteDataSel;
  logic [1:0]       regIn;
  logic [1:0]       fault;
  logic [CNT_W-1:0] retired;

  mc_controller #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .zero(zero), .mem_ready(mem_ready),
    .ALUcontrol(ALUcontrol), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSel(pcSel),
    .pcWrite(pcWrite), .irWrite(irWrite), .iord(iord), .memRead(memRead),
    .memWrite(memWrite), .regWrite(regWrite), .regWriteDataSel(regWriteDataSel),
    .regIn(regIn), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       alu_ctl;
    logic             src_a;
    logic [1:0]       src_b;
    logic [1:0]       pc_sel;
    logic             pc_wr;
    logic             ir_wr;
    logic             iord;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_wr;
    logic [1:0]       wd_sel;
    logic [1:0]       reg_in;
    logic [1:0]       fault;
    logic [CNT_W-1:0] retired;
  } ctrl_t;

  ctrl_t act;
  assign act = {ALUcontrol, aluSrcA, aluSrcB, pcSel, pcWrite, irWrite, iord, memRead,
                memWrite, regWrite, regWriteDataSel, regIn, fault, retired};

  ctrl_t exp_q[$];
  ctrl_t mon_e;
  int    n_checks = 0;
  int    n_fail = 0;

  // Reference model state
  logic [CNT_W-1:0] m_retired = '0;
  logic [1:0]       m_fault = 2'b00;
  logic [5:0]       cur_op = 6'b000000;
  int               abort_left = -1;
  bit               aborted = 1'b0;

  localparam logic [5:0] LEGAL_OPS [10] = '{6'b000000, 6'b001000, 6'b001100, 6'b100011,
    6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b100000};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (act !== mon_e) begin
        n_fail++;
        $display("FAIL ctrl t=%0t got=%h expected=%h (alu,srcA,srcB,pcSel,pcW,irW,iord,mRd,mWr,rW,wdSel,regIn,fault,retired)",
                 $time, act, mon_e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic ctrl_t base();
    ctrl_t c;
    c = '0;
    c.fault = m_fault;
    c.retired = m_retired;
    return c;
  endfunction

  function automatic ctrl_t mem_w(input int st, input logic mr);
    ctrl_t c;
    c = base();
    if (st == 0) begin
      c.mem_rd = 1'b1; c.src_b = 2'b01; c.ir_wr = mr; c.pc_wr = mr;
    end else if (st == 1) begin
      c.iord = 1'b1; c.mem_rd = 1'b1;
    end else begin
      c.iord = 1'b1; c.mem_wr = 1'b1;
    end
    return c;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 10; i++) if (LEGAL_OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(input logic rst, input logic mr, input logic z, input ctrl_t e);
    @(posedge clk);
    #1;
    rst_n = ~rst;
    mem_ready = mr;
    zero = z;
    opCode = cur_op;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    ctrl_t c;
    m_retired = '0;
    m_fault = 2'b00;
    c = '0;
    c.mem_rd = 1'b1;
    c.src_b = 2'b01;
    for (int i = 0; i < n; i++) cyc(1'b1, rbit(), rbit(), c);
  endtask

  task automatic fault_hold(input logic [1:0] code);
    m_fault = code;
    for (int i = 0; i < 20; i++) cyc(1'b0, rbit(), rbit(), base());
    do_reset(2);
  endtask

  // One instruction cycle, or the point where a planned reset cuts the instruction short.
  task automatic step(input logic mr, input logic z, input ctrl_t e);
    if (aborted) return;
    if (abort_left == 0) begin
      abort_left = -1;
      aborted = 1'b1;
      do_reset(2);
      return;
    end
    if (abort_left > 0) abort_left--;
    cyc(1'b0, mr, z, e);
  endtask

  task automatic mem_phase(input int st, input int w, output bit ok);
    if (w >= WAIT_LIMIT) begin
      for (int i = 0; i < WAIT_LIMIT; i++) step(1'b0, rbit(), mem_w(st, 1'b0));
      ok = 1'b0;
    end else begin
      for (int i = 0; i < w; i++) step(1'b0, rbit(), mem_w(st, 1'b0));
      step(1'b1, rbit(), mem_w(st, 1'b1));
      ok = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int zf);
    ctrl_t c;
    bit    ok;
    logic  z;
    cur_op = op;
    aborted = 1'b0;
    mem_phase(0, wf, ok);
    if (!ok) begin
      if (!aborted) fault_hold(2'b10);
      return;
    end
    c = base(); c.src_b = 2'b11;
    step(rbit(), rbit(), c);
    case (op)
      6'b000000: begin
        c = base(); c.src_a = 1'b1; c.alu_ctl = 2'b10;
        step(rbit(), rbit(), c);
        c = base(); c.reg_wr = 1'b1; c.reg_in = 2'b01;
        step(rbit(), rbit(), c);
      end
      6'b001000, 6'b001100: begin
        c = base(); c.src_a = 1'b1; c.src_b = 2'b10;
        c.alu_ctl = (op == 6'b001100) ? 2'b11 : 2'b00;
        step(rbit(), rbit(), c);
        c = base(); c.reg_wr = 1'b1;
        step(rbit(), rbit(), c);
      end
      6'b100011, 6'b101011: begin
        c = base(); c.src_a = 1'b1; c.src_b = 2'b10;
        step(rbit(), rbit(), c);
        mem_phase((op == 6'b100011) ? 1 : 2, wm, ok);
        if (!ok) begin
          if (!aborted) fault_hold(2'b10);
          return;
        end
        if (op == 6'b100011) begin
          c = base(); c.reg_wr = 1'b1; c.wd_sel = 2'b01;
          step(rbit(), rbit(), c);
        end
      end
      6'b000100, 6'b000101: begin
        z = (zf < 0) ? rbit() : 1'(zf);
        c = base(); c.src_a = 1'b1; c.alu_ctl = 2'b01; c.pc_sel = 2'b11;
        c.pc_wr = (op == 6'b000100) ? z : ~z;
        step(rbit(), z, c);
      end
      6'b000010: begin
        c = base(); c.pc_sel = 2'b01; c.pc_wr = 1'b1;
        step(rbit(), rbit(), c);
      end
      6'b000011: begin
        c = base(); c.pc_sel = 2'b01; c.pc_wr = 1'b1; c.reg_wr = 1'b1;
        c.wd_sel = 2'b10; c.reg_in = 2'b10;
        step(rbit(), rbit(), c);
      end
      6'b100000: begin
        c = base(); c.pc_sel = 2'b10; c.pc_wr = 1'b1;
        step(rbit(), rbit(), c);
      end
      default: begin
        if (!aborted) fault_hold(2'b01);
        return;
      end
    endcase
    if (!aborted) m_retired = m_retired + CNT_W'(1);
  endtask

  initial begin
    logic [5:0] op;
    int wf;
    int wm;
    do_reset(3);
    // Directed cases
    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b100011, 0, 3, -1);
    run_instr(6'b000100, 0, 0, 1);
    run_instr(6'b000101, 0, 0, 1);
    run_instr(6'b000100, 0, 0, 0);
    run_instr(6'b000101, 0, 0, 0);
    run_instr(6'b000011, 0, 0, -1);
    run_instr(6'b000010, 2, 0, -1);
    run_instr(6'b100000, 0, 0, -1);
    run_instr(6'b001000, 0, 0, -1);
    run_instr(6'b001100, 1, 0, -1);
    run_instr(6'b101011, 0, 2, -1);
    run_instr(6'b000010, WAIT_LIMIT - 1, 0, -1);
    run_instr(6'b101011, 0, WAIT_LIMIT - 1, -1);
    run_instr(6'b100011, 0, WAIT_LIMIT - 1, -1);
    run_instr(6'b000010, WAIT_LIMIT, 0, -1);
    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b100011, 0, WAIT_LIMIT, -1);
    run_instr(6'b101011, 0, WAIT_LIMIT, -1);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(6'b000000, 0, 0, -1);
    abort_left = 4;
    run_instr(6'b100011, 0, 3, -1);
    abort_left = 3;
    run_instr(6'b101011, 0, 0, -1);
    // Counter wrap
    for (int i = 0; i < (1 << CNT_W) + 3; i++) run_instr(6'b000010, 0, 0, -1);
    // Random mix
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = LEGAL_OPS[$urandom_range(0, 9)];
      end
      wf = ($urandom_range(0, 24) == 0) ? WAIT_LIMIT : $urandom_range(0, 3);
      wm = ($urandom_range(0, 24) == 0) ? WAIT_LIMIT : $urandom_range(0, WAIT_LIMIT - 1);
      if ($urandom_range(0, 29) == 0) abort_left = $urandom_range(1, 5);
      run_instr(op, wf, wm, -1);
      abort_left = -1;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    if (n_checks == 0) begin
      n_fail++;
      $display("FAIL monitor: got 0 checks expected >0");
    end
    if (act.retired !== m_retired) begin
      n_fail++;
      $display("FAIL final retired: got %h expected %h", act.retired, m_retired);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle successor to the single-cycle main controller. A Moore/Mealy FSM sequences each MIPS instruction (add/sub/and/or/slt R-type, addi, andi, lw, sw, j, jal, beq, bne, jr) over 3–5 cycles through a shared ALU and a single memory port. A `mem_ready` handshake adds memory wait states. It also adds a wait-state timeout, a sticky fault trap and a retired-instruction counter, none of which the single-cycle controller has. It sits between the IR/`zero` flag and the multicycle datapath muxes.

## Interface
- `WAIT_LIMIT`, 8: maximum cycles a memory state may wait for `mem_ready` before faulting (≥1).
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, **asynchronous, active-low**.
- `opCode` in 6: IR[31:26], held stable by the datapath from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `ALUcontrol` out 2: 00 add, 01 sub, 10 funct-decoded, 11 and.
- `aluSrcA` out 1: 0 PC, 1 rs.
- `aluSrcB` out 2: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `pcSel` out 2: 0 ALU result, 1 jump target, 2 rs, 3 ALUOut (branch target).
- `pcWrite` out 1: PC load enable.
- `irWrite` out 1: IR load enable.
- `iord` out 1: memory address, 0 PC, 1 ALUOut.
- `memRead`, `memWrite` out 1 each: memory request strobes.
- `regWrite` out 1: register file write enable.
- `regWriteDataSel` out 2: 0 ALUOut, 1 MDR, 2 PC (link).
- `regIn` out 2: destination, 0 rt, 1 rd, 2 $31.
- `fault` out 2: 00 none, 01 illegal opcode, 10 memory timeout. Sticky.
- `retired` out CNT_W: completed-instruction count.

## Operation
- Outputs are combinational from state. `pcWrite` in BRANCH and `pcWrite`/`irWrite` in FETCH also depend on inputs. Any output not listed for a state is 0.
- **FETCH**: `memRead`=1, `iord`=0, `aluSrcA`=0, `aluSrcB`=01, `ALUcontrol`=00, `pcSel`=0. `irWrite` and `pcWrite` equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**: `aluSrcA`=0, `aluSrcB`=11, `ALUcontrol`=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC_R
  - 001000 or 001100 → EXEC_I
  - 100011 or 101011 → MEM_ADDR
  - 000100 or 000101 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - 100000 → JR
  - any other → FAULT with code 01
- **EXEC_R**: `aluSrcA`=1, `aluSrcB`=00, `ALUcontrol`=10. Next: WB_R.
- **WB_R**: `regWrite`=1, `regIn`=1, `regWriteDataSel`=0. Next: FETCH.
- **EXEC_I**: `aluSrcA`=1, `aluSrcB`=10. `ALUcontrol`=00 for addi, 11 for andi. Next: WB_I.
- **WB_I**: `regWrite`=1, `regIn`=0, `regWriteDataSel`=0. Next: FETCH.
- **MEM_ADDR**: `aluSrcA`=1, `aluSrcB`=10, `ALUcontrol`=00. Next: MEM_RD for lw, MEM_WR for sw.
- **MEM_RD**: `iord`=1, `memRead`=1. Waits for `mem_ready`, then WB_M.
- **WB_M**: `regWrite`=1, `regWriteDataSel`=1, `regIn`=0. Next: FETCH.
- **MEM_WR**: `iord`=1, `memWrite`=1. Waits for `mem_ready`, then FETCH.
- **BRANCH**: `aluSrcA`=1, `aluSrcB`=00, `ALUcontrol`=01, `pcSel`=3. `pcWrite`=`zero` for beq, `~zero` for bne. Next: FETCH.
- **JUMP**: `pcSel`=1, `pcWrite`=1. Next: FETCH.
- **JAL**: `pcSel`=1, `pcWrite`=1, `regWrite`=1, `regWriteDataSel`=2, `regIn`=2. The link value is PC, already advanced by 4 in FETCH. Next: FETCH.
- **JR**: `pcSel`=2, `pcWrite`=1. Next: FETCH.
- **FAULT**: all strobes 0. Terminal: leaves only on reset.
- **Wait counter**:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle the FSM stays in one of those states with `mem_ready`=0.
  - If it reaches `WAIT_LIMIT` with `mem_ready`=0 in that cycle: next state FAULT, code 10.
  - If `mem_ready`=1 in the same cycle the limit is reached, the access succeeds.
- **Retired counter**:
  - Increments by 1 on every transition into FETCH from a non-FETCH state.
  - Wraps modulo 2^CNT_W.
  - Does not increment on entry to FAULT.

## Timing
- **Reset** (`rst_n`=0, asynchronous):
  - State = FETCH; `retired`=0; `fault`=00; wait counter = 0.
  - While `rst_n`=0, `pcWrite`, `irWrite`, `memWrite` and `regWrite` are forced to 0.
  - FETCH decode is visible: `memRead`=1, `aluSrcB`=01, all other outputs 0.
- Reset asserted mid-instruction aborts the instruction immediately. No further register or memory write occurs. The partial instruction is not counted.
- **Latency with `mem_ready`=1 on first request**:

  | Instruction | Cycles |
  |---|---|
  | j, jr, jal, beq, bne | 3 |
  | R-type, addi, andi, sw | 4 |
  | lw | 5 |

- Each wait cycle adds 1 cycle of latency.
- `mem_ready` is sampled only in FETCH, MEM_RD and MEM_WR. It is ignored elsewhere.
- The FAULT code is latched on the clock edge that enters FAULT.

## Test plan
- Reset then `mem_ready`=1 constant, opCode 000000 → states FETCH, DECODE, EXEC_R, WB_R, FETCH. `regWrite`=1 with `regIn`=1 in cycle 4 only. `retired`=1 after cycle 4.
- lw (100011) with `mem_ready` low for 3 cycles in MEM_RD → `memRead`=1, `iord`=1 held for 4 cycles. WB_M asserts `regWriteDataSel`=1. Total 8 cycles.
- beq with `zero`=1 → `pcWrite`=1, `pcSel`=3 in BRANCH. bne with `zero`=1 → `pcWrite`=0. Each takes 3 cycles.
- jal → single cycle with `pcWrite`=1, `regWrite`=1, `regIn`=2, `regWriteDataSel`=2. Then FETCH.
- opCode 111111 → `fault`=01 after DECODE. Strobes 0 and `retired` frozen for 20 cycles. `rst_n` pulse → `fault`=00, back in FETCH.
- `WAIT_LIMIT`=8, `mem_ready`=0 in FETCH → `fault`=10 on the 8th cycle edge. Repeat with `mem_ready`=1 on the 8th cycle → DECODE, no fault. `retired` wraps from 0xFFFF to 0 with `CNT_W`=16.
